// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] FWD_RF   = 2'b00;
    localparam logic [SEL_W-1:0] FWD_WB   = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM  = 2'b10;
    localparam logic [SEL_W-1:0] FWD_RSVD = 2'b11;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rw;
        logic              mr;
    } shadow_t;

    // Stage holds a live register write to r (r0 excluded unless zero_en).
    function automatic logic shadow_match(shadow_t s, logic [REG_AW-1:0] r, logic zero_en);
        return s.v & s.rw & (s.rd == r) & (zero_en | (r != '0));
    endfunction

    // Operand select: youngest producer wins. A WB hit maps to the register
    // file because the register file is write-through.
    function automatic logic [SEL_W-1:0] pick_sel(shadow_t ex, shadow_t mem, shadow_t wb,
                                                  logic [REG_AW-1:0] r, logic zero_en);
        if (shadow_match(ex, r, zero_en))       return FWD_MEM;
        else if (shadow_match(mem, r, zero_en)) return FWD_WB;
        else if (shadow_match(wb, r, zero_en))  return FWD_RF;
        else                                    return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request / hazard-control response bundle.
interface hazard_fwd_ctrl_if;
    import hazard_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              ext_stall;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic              stall_if;
    logic              bubble_ex;
    logic              flush_id;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               ex_branch_taken, ext_stall,
        input  fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_id
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
               ex_branch_taken, ext_stall,
        output fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_id
    );

endinterface

// File: rtl/stage_shadow_reg.sv
// One pipeline-stage shadow {v,rd,rw,mr}; hold beats clear, clear beats load.
module stage_shadow_reg
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    hold,
    input  logic    clear,
    input  shadow_t d,
    output shadow_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            if (clear) q <= '0;
            else       q <= d;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding select generation for the EX stage.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter bit ZERO_FWD_EN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_ctrl_if.slave  hif
);

    shadow_t ex_q, mem_q, wb_q;
    shadow_t ex_d, mem_d;
    logic    flush_c, load_use_c;
    logic [SEL_W-1:0] sel_a, sel_b;

    always_comb begin
        flush_c    = hif.ex_branch_taken & ~hif.ext_stall;
        load_use_c = hif.id_valid & ex_q.v & ex_q.mr &
                     (shadow_match(ex_q, hif.id_rs1, ZERO_FWD_EN) |
                      shadow_match(ex_q, hif.id_rs2, ZERO_FWD_EN));
        ex_d       = '{v: hif.id_valid, rd: hif.id_rd, rw: hif.id_reg_write, mr: hif.id_mem_read};
        mem_d      = ex_q;
        mem_d.mr   = 1'b0;
    end

    stage_shadow_reg u_ex (
        .clk   (clk),
        .reset (reset),
        .hold  (hif.ext_stall),
        .clear (flush_c | load_use_c),
        .d     (ex_d),
        .q     (ex_q)
    );

    stage_shadow_reg u_mem (
        .clk   (clk),
        .reset (reset),
        .hold  (hif.ext_stall),
        .clear (1'b0),
        .d     (mem_d),
        .q     (mem_q)
    );

    stage_shadow_reg u_wb (
        .clk   (clk),
        .reset (reset),
        .hold  (hif.ext_stall),
        .clear (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    // Selects are resolved while the consumer is still in ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_a <= FWD_RF;
            sel_b <= FWD_RF;
        end else if (!hif.ext_stall) begin
            if (flush_c | load_use_c) begin
                sel_a <= FWD_RF;
                sel_b <= FWD_RF;
            end else begin
                sel_a <= pick_sel(ex_q, mem_q, wb_q, hif.id_rs1, ZERO_FWD_EN);
                sel_b <= pick_sel(ex_q, mem_q, wb_q, hif.id_rs2, ZERO_FWD_EN);
            end
        end
    end

    assign hif.fwd_a_sel = sel_a;
    assign hif.fwd_b_sel = sel_b;
    assign hif.flush_id  = flush_c;
    assign hif.stall_if  = load_use_c & ~flush_c;
    assign hif.bubble_ex = load_use_c & ~flush_c;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding, load-use, flush, stall, r0, reset.
module tb_hazard_fwd_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hazard_fwd_ctrl_if hif ();

    hazard_fwd_ctrl #(.ZERO_FWD_EN(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                          input logic rw, input logic mr);
        hif.id_valid     = v;
        hif.id_rs1       = REG_AW'(rs1);
        hif.id_rs2       = REG_AW'(rs2);
        hif.id_rd        = REG_AW'(rd);
        hif.id_reg_write = rw;
        hif.id_mem_read  = mr;
        #1;
    endtask

    task automatic drain();
        hif.ex_branch_taken = 1'b0;
        hif.ext_stall       = 1'b0;
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hif.ex_branch_taken = 1'b0;
        hif.ext_stall       = 1'b0;
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        #1;
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL reset_sel got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
        total++; if ({hif.stall_if, hif.bubble_ex, hif.flush_id} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b exp=000", {hif.stall_if, hif.bubble_ex, hif.flush_id}); end
    endtask

    task automatic test_fwd_mem();
        drain();
        set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);      // add r3,r1,r2
        step();
        set_id(1'b1, 3, 1, 4, 1'b1, 1'b0);      // add r4,r3,r1
        total++; if (hif.stall_if !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", hif.stall_if); end
        step();
        total++; if (hif.fwd_a_sel !== 2'b10) begin bad++; $display("FAIL b2b_sel_a got=%b exp=10", hif.fwd_a_sel); end
        total++; if (hif.fwd_b_sel !== 2'b00) begin bad++; $display("FAIL b2b_sel_b got=%b exp=00", hif.fwd_b_sel); end
    endtask

    task automatic test_fwd_wb();
        drain();
        set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);      // add r3
        step();
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);      // nop
        step();
        set_id(1'b1, 2, 3, 5, 1'b1, 1'b0);      // sub r5,r2,r3
        step();
        total++; if (hif.fwd_b_sel !== 2'b01) begin bad++; $display("FAIL gap_sel_b got=%b exp=01", hif.fwd_b_sel); end
        total++; if (hif.fwd_a_sel !== 2'b00) begin bad++; $display("FAIL gap_sel_a got=%b exp=00", hif.fwd_a_sel); end
        drain();
        set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);      // add r3
        step();
        set_id(1'b1, 1, 1, 3, 1'b1, 1'b0);      // add r3 again
        step();
        set_id(1'b1, 2, 3, 5, 1'b1, 1'b0);      // sub r5,r2,r3
        step();
        total++; if (hif.fwd_b_sel !== 2'b10) begin bad++; $display("FAIL youngest_sel_b got=%b exp=10", hif.fwd_b_sel); end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1'b1, 1, 2, 6, 1'b1, 1'b1);      // lw r6
        step();
        set_id(1'b1, 6, 6, 7, 1'b1, 1'b0);      // add r7,r6,r6
        total++; if ({hif.stall_if, hif.bubble_ex, hif.flush_id} !== 3'b110) begin bad++; $display("FAIL lu_ctl got=%b exp=110", {hif.stall_if, hif.bubble_ex, hif.flush_id}); end
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL lu_bubble_sel got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
        total++; if ({hif.stall_if, hif.bubble_ex} !== 2'b00) begin bad++; $display("FAIL lu_one_bubble got=%b exp=00", {hif.stall_if, hif.bubble_ex}); end
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0101) begin bad++; $display("FAIL lu_after_sel got=%b exp=0101", {hif.fwd_a_sel, hif.fwd_b_sel}); end
    endtask

    task automatic test_flush();
        drain();
        set_id(1'b1, 1, 2, 6, 1'b1, 1'b1);      // lw r6
        step();
        hif.ex_branch_taken = 1'b1;
        set_id(1'b1, 6, 6, 7, 1'b1, 1'b0);      // dependent add r7
        total++; if ({hif.stall_if, hif.bubble_ex, hif.flush_id} !== 3'b001) begin bad++; $display("FAIL flush_ctl got=%b exp=001", {hif.stall_if, hif.bubble_ex, hif.flush_id}); end
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL flush_sel got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
        hif.ex_branch_taken = 1'b0;
        set_id(1'b1, 7, 9, 8, 1'b1, 1'b0);      // would hit r7 if EX had kept it
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL flush_squash got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
    endtask

    task automatic test_ext_stall();
        drain();
        set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);      // add r3
        step();
        set_id(1'b1, 3, 1, 4, 1'b1, 1'b0);      // add r4,r3,r1
        step();
        set_id(1'b1, 4, 3, 5, 1'b1, 1'b0);      // add r5,r4,r3
        hif.ext_stall       = 1'b1;
        hif.ex_branch_taken = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (hif.flush_id !== 1'b0) begin bad++; $display("FAIL stall_flush[%0d] got=%b exp=0", i, hif.flush_id); end
            step();
            total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b1000) begin bad++; $display("FAIL stall_hold[%0d] got=%b exp=1000", i, {hif.fwd_a_sel, hif.fwd_b_sel}); end
        end
        hif.ext_stall       = 1'b0;
        hif.ex_branch_taken = 1'b0;
        #1;
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b1001) begin bad++; $display("FAIL stall_resume got=%b exp=1001", {hif.fwd_a_sel, hif.fwd_b_sel}); end
    endtask

    task automatic test_r0_and_async_reset();
        drain();
        set_id(1'b1, 1, 2, 0, 1'b1, 1'b0);      // add r0
        step();
        set_id(1'b1, 0, 0, 1, 1'b1, 1'b0);      // add r1,r0,r0
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL r0_sel got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
        set_id(1'b1, 1, 2, 0, 1'b1, 1'b1);      // lw r0
        step();
        set_id(1'b1, 0, 0, 2, 1'b1, 1'b0);      // add r2,r0,r0
        total++; if (hif.stall_if !== 1'b0) begin bad++; $display("FAIL r0_no_lu got=%b exp=0", hif.stall_if); end
        drain();
        set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);      // add r3
        step();
        set_id(1'b1, 3, 3, 4, 1'b1, 1'b0);      // add r4,r3,r3
        step();
        set_id(1'b1, 4, 4, 5, 1'b1, 1'b1);      // lw r5,(r4)
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b1010) begin bad++; $display("FAIL pre_rst_sel got=%b exp=1010", {hif.fwd_a_sel, hif.fwd_b_sel}); end
        set_id(1'b1, 5, 5, 6, 1'b1, 1'b0);      // add r6,r5,r5
        total++; if (hif.stall_if !== 1'b1) begin bad++; $display("FAIL pre_rst_lu got=%b exp=1", hif.stall_if); end
        hif.ext_stall = 1'b1;
        #1;
        reset = 1'b1;                           // mid-cycle, no clock edge
        #1;
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL async_rst_sel got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
        total++; if ({hif.stall_if, hif.bubble_ex, hif.flush_id} !== 3'b000) begin bad++; $display("FAIL async_rst_ctl got=%b exp=000", {hif.stall_if, hif.bubble_ex, hif.flush_id}); end
        step();
        reset = 1'b0;
        hif.ext_stall = 1'b0;
        set_id(1'b1, 5, 4, 7, 1'b1, 1'b0);      // add r7,r5,r4
        step();
        total++; if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL post_rst_sel got=%b exp=0000", {hif.fwd_a_sel, hif.fwd_b_sel}); end
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_flush();
        test_ext_stall();
        test_r0_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
